xa_bf_param_xfer: RTL and testbench

Sound-speed / position-vector parameter transfer engine for the beam forming stage. Started by the `param_start` pulse from the beam forming control block, it copies `P_word_num` 32-bit words from the parameter source RAM into the beam-former coefficient RAM, honouring destination backpressure through an internal 4-entry buffer. It returns the `param_end` pulse that advances the control state machine. An in-progress transfer is aborted when the frame counter changes.

---
 rtl/xa_bf_param_xfer.sv | 137 +++++++++++++
 tb/tb_xa_bf_param_xfer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xa_bf_param_xfer.sv
// rtl/xa_bf_param_xfer.sv - beam-former parameter RAM-to-RAM transfer engine with frame-change abort
// Optional running checksum of transferred words: define XA_BF_PARAM_XFER_SUM_EN.
module xa_bf_param_xfer #(
    parameter logic [9:0] P_word_num  = 10'd64,
    parameter logic [1:0] P_src_lat   = 2'd2,
    parameter logic [3:0] P_frame_max = 4'h7
) (
    input  logic        i_clk156m,
    input  logic        i_arst_n,
    input  logic        i_param_start,
    input  logic [3:0]  i_frame_time,
    output logic        o_src_rd,
    output logic [9:0]  o_src_addr,
    input  logic [31:0] i_src_data,
    output logic        o_dst_we,
    output logic [9:0]  o_dst_addr,
    output logic [31:0] o_dst_data,
    input  logic        i_dst_ready,
    output logic        o_param_end,
    output logic        o_busy,
    output logic        o_abort,
    output logic [31:0] o_checksum
);
    localparam int          LAT   = int'(P_src_lat);
    localparam logic [10:0] WORDS = {1'b0, P_word_num};

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

    state_t         state;
    logic [10:0]    rd_cnt;
    logic [10:0]    wr_cnt;
    logic [2:0]     outstanding;
    logic [2:0]     occ;
    logic [LAT-1:0] vpipe;
    logic [LAT-1:0] vpipe_shift;
    logic [31:0]    buf_mem [4];
    logic [1:0]     wr_ptr;
    logic [1:0]     rd_ptr;
    logic [3:0]     frame_shadow;
    logic           frame_chg;
    logic           accept;
    logic           ret;

    assign frame_chg   = (i_frame_time != frame_shadow);
    assign ret         = vpipe[LAT-1];
    assign o_busy      = (state != S_IDLE);
    // Reads are throttled so buffered plus in-flight words never exceed the 4-entry buffer.
    assign o_src_rd    = (state == S_XFER) && (rd_cnt < WORDS) &&
                         (({1'b0, occ} + {1'b0, outstanding}) < 4'd4);
    assign o_src_addr  = rd_cnt[9:0];
    assign o_dst_we    = (occ != 3'd0);
    assign o_dst_addr  = wr_cnt[9:0];
    assign o_dst_data  = buf_mem[rd_ptr];
    assign accept      = o_dst_we & i_dst_ready;
    assign o_param_end = (state == S_DONE) && !frame_chg;

    always_comb begin
        vpipe_shift    = vpipe << 1;
        vpipe_shift[0] = o_src_rd;
    end

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= S_IDLE;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            outstanding  <= '0;
            occ          <= '0;
            vpipe        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frame_shadow <= P_frame_max;
            o_abort      <= 1'b0;
            for (int i = 0; i < 4; i++) buf_mem[i] <= '0;
        end else begin
            frame_shadow <= i_frame_time;
            o_abort      <= 1'b0;
            if (state != S_IDLE && frame_chg) begin
                // Flushing the valid pipe is what discards late source data.
                state       <= S_IDLE;
                o_abort     <= 1'b1;
                rd_cnt      <= '0;
                wr_cnt      <= '0;
                outstanding <= '0;
                occ         <= '0;
                vpipe       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
            end else begin
                vpipe       <= vpipe_shift;
                outstanding <= outstanding + {2'b0, o_src_rd} - {2'b0, ret};
                occ         <= occ + {2'b0, ret} - {2'b0, accept};
                if (ret) begin
                    buf_mem[wr_ptr] <= i_src_data;
                    wr_ptr          <= wr_ptr + 2'd1;
                end
                if (accept) begin
                    rd_ptr <= rd_ptr + 2'd1;
                    wr_cnt <= wr_cnt + 11'd1;
                end
                if (o_src_rd) rd_cnt <= rd_cnt + 11'd1;
                case (state)
                    S_IDLE: if (i_param_start) begin
                        state       <= S_XFER;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        outstanding <= '0;
                    end
                    S_XFER:  if (o_src_rd && rd_cnt == WORDS - 11'd1) state <= S_DRAIN;
                    S_DRAIN: if (accept && wr_cnt == WORDS - 11'd1) state <= S_DONE;
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef XA_BF_PARAM_XFER_SUM_EN
    logic [31:0] sum_acc;

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sum_acc    <= '0;
            o_checksum <= '0;
        end else if (state == S_IDLE && i_param_start) begin
            sum_acc <= '0;
        end else if (accept) begin
            sum_acc <= sum_acc + o_dst_data;
            if (state == S_DRAIN && wr_cnt == WORDS - 11'd1 && !frame_chg)
                o_checksum <= sum_acc + o_dst_data;
        end
    end
`else
    assign o_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_xa_bf_param_xfer.sv
// tb/tb_xa_bf_param_xfer.sv - randomized self-checking bench for xa_bf_param_xfer
module tb_xa_bf_param_xfer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  frame_time;
    logic        dst_ready;
    logic        start_v   [3];
    logic        src_rd    [3];
    logic [9:0]  src_addr  [3];
    logic [31:0] src_data  [3];
    logic        dst_we    [3];
    logic [9:0]  dst_addr  [3];
    logic [31:0] dst_data  [3];
    logic        param_end [3];
    logic        busy      [3];
    logic        abort_p   [3];
    logic [31:0] checksum  [3];
    logic [31:0] src_mem   [1024];
    logic [9:0]  pa [2];
    logic [9:0]  pb;
    logic [9:0]  pc [3];

    int errors = 0;
    int checks = 0;
    int r_nacc, r_bad, r_first_rd, r_first_we, r_end_cyc, r_end_cnt;
    int r_abort_cyc, r_max_fl, r_hold_bad, r_trig, r_last_addr;
    logic        r_abort_busy;
    logic [31:0] r_csum;

    always #3 clk = ~clk;

    always @(posedge clk) begin
        pa[0] <= src_addr[0]; pa[1] <= pa[0];
        pb    <= src_addr[1];
        pc[0] <= src_addr[2]; pc[1] <= pc[0]; pc[2] <= pc[1];
    end
    assign src_data[0] = src_mem[pa[1]];
    assign src_data[1] = src_mem[pb];
    assign src_data[2] = src_mem[pc[2]];

    xa_bf_param_xfer u_dut_a (
        .i_clk156m(clk), .i_arst_n(rst_n), .i_param_start(start_v[0]), .i_frame_time(frame_time),
        .o_src_rd(src_rd[0]), .o_src_addr(src_addr[0]), .i_src_data(src_data[0]),
        .o_dst_we(dst_we[0]), .o_dst_addr(dst_addr[0]), .o_dst_data(dst_data[0]), .i_dst_ready(dst_ready),
        .o_param_end(param_end[0]), .o_busy(busy[0]), .o_abort(abort_p[0]), .o_checksum(checksum[0]));

    xa_bf_param_xfer #(.P_word_num(10'd1), .P_src_lat(2'd1)) u_dut_b (
        .i_clk156m(clk), .i_arst_n(rst_n), .i_param_start(start_v[1]), .i_frame_time(frame_time),
        .o_src_rd(src_rd[1]), .o_src_addr(src_addr[1]), .i_src_data(src_data[1]),
        .o_dst_we(dst_we[1]), .o_dst_addr(dst_addr[1]), .o_dst_data(dst_data[1]), .i_dst_ready(dst_ready),
        .o_param_end(param_end[1]), .o_busy(busy[1]), .o_abort(abort_p[1]), .o_checksum(checksum[1]));

    xa_bf_param_xfer #(.P_word_num(10'd1023), .P_src_lat(2'd3)) u_dut_c (
        .i_clk156m(clk), .i_arst_n(rst_n), .i_param_start(start_v[2]), .i_frame_time(frame_time),
        .o_src_rd(src_rd[2]), .o_src_addr(src_addr[2]), .i_src_data(src_data[2]),
        .o_dst_we(dst_we[2]), .o_dst_addr(dst_addr[2]), .o_dst_data(dst_data[2]), .i_dst_ready(dst_ready),
        .o_param_end(param_end[2]), .o_busy(busy[2]), .o_abort(abort_p[2]), .o_checksum(checksum[2]));

    function automatic logic [31:0] exp_sum(input int n);
        logic [31:0] s;
        s = 32'd0;
`ifdef XA_BF_PARAM_XFER_SUM_EN
        for (int k = 0; k < n; k++) s = s + src_mem[k];
`endif
        return s;
    endfunction

    task automatic run_xfer(input int sel, input bit bp, input int abort_after, input int dup_start, input int limit);
        int c, issued, post, trig, inflight;
        bit hold_pend;
        logic [9:0]  h_addr;
        logic [31:0] h_data;
        r_nacc = 0; r_bad = 0; r_first_rd = -1; r_first_we = -1; r_end_cyc = -1; r_end_cnt = 0;
        r_abort_cyc = -1; r_abort_busy = 1'b1; r_max_fl = 0; r_hold_bad = 0; r_csum = 32'd0; r_last_addr = -1;
        issued = 0; post = 0; trig = -1; hold_pend = 0; h_addr = '0; h_data = '0;
        @(posedge clk); #1 start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v[sel] = 1'b0;
        c = 1;
        while (c < limit && post < 6) begin
            dst_ready    = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            start_v[sel] = (c == dup_start);
            @(negedge clk);
            inflight = issued - r_nacc;
            if (inflight > r_max_fl) r_max_fl = inflight;
            if (src_rd[sel]) begin
                issued++;
                if (r_first_rd < 0) r_first_rd = c;
            end
            if (hold_pend && (!dst_we[sel] || dst_addr[sel] !== h_addr || dst_data[sel] !== h_data)) r_hold_bad++;
            hold_pend = 0;
            if (dst_we[sel]) begin
                if (r_first_we < 0) r_first_we = c;
                if (dst_ready) begin
                    if (r_nacc > 1023 || dst_addr[sel] !== 10'(r_nacc) || dst_data[sel] !== src_mem[r_nacc & 1023]) r_bad++;
                    r_last_addr = int'(dst_addr[sel]);
                    r_nacc++;
                    if (abort_after > 0 && r_nacc == abort_after) trig = c + 1;
                end else begin
                    hold_pend = 1; h_addr = dst_addr[sel]; h_data = dst_data[sel];
                end
            end
            if (param_end[sel]) begin
                r_end_cnt++; r_end_cyc = c; r_csum = checksum[sel];
            end
            if (abort_p[sel]) begin
                r_abort_cyc = c; r_abort_busy = busy[sel];
            end
            if (r_end_cnt > 0 || r_abort_cyc >= 0) post++;
            @(posedge clk); #1;
            if (c + 1 == trig) frame_time = frame_time + 4'd1;
            c++;
        end
        start_v[sel] = 1'b0;
        dst_ready    = 1'b1;
        r_trig       = trig;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({src_rd[i], src_addr[i], dst_we[i], dst_addr[i], dst_data[i], param_end[i], busy[i], abort_p[i], checksum[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: got busy=%b rd=%b we=%b addr=%0d data=%0h, required all zero",
                         i, busy[i], src_rd[i], dst_we[i], dst_addr[i], dst_data[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 frame_time = 4'($urandom);
            @(negedge clk);
            checks++;
            if (abort_p[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL idle_frame_change: got abort=%b busy=%b, required 0 0", abort_p[0], busy[0]);
            end
        end
    endtask

    task automatic test_nominal();
        for (int k = 0; k < 1024; k++) src_mem[k] = 32'(k);
        run_xfer(0, 0, 0, -1, 400);
        checks++; if (r_first_rd !== 1) begin errors++; $display("FAIL nom_first_rd: got %0d required 1", r_first_rd); end
        checks++; if (r_first_we !== 4) begin errors++; $display("FAIL nom_first_we: got %0d required 4", r_first_we); end
        checks++; if (r_end_cyc !== 68) begin errors++; $display("FAIL nom_end_cycle: got %0d required 68", r_end_cyc); end
        checks++; if (r_end_cnt !== 1)  begin errors++; $display("FAIL nom_end_count: got %0d required 1", r_end_cnt); end
        checks++; if (r_nacc !== 64)    begin errors++; $display("FAIL nom_writes: got %0d required 64", r_nacc); end
        checks++; if (r_bad !== 0)      begin errors++; $display("FAIL nom_order: got %0d bad writes required 0", r_bad); end
        checks++; if (r_csum !== exp_sum(64)) begin errors++; $display("FAIL nom_checksum: got %0d required %0d", r_csum, exp_sum(64)); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 1024; k++) src_mem[k] = $urandom;
        run_xfer(0, 1, 0, -1, 2000);
        checks++; if (r_nacc !== 64)    begin errors++; $display("FAIL bp_writes: got %0d required 64", r_nacc); end
        checks++; if (r_bad !== 0)      begin errors++; $display("FAIL bp_order: got %0d bad writes required 0", r_bad); end
        checks++; if (r_end_cnt !== 1)  begin errors++; $display("FAIL bp_end_count: got %0d required 1", r_end_cnt); end
        checks++; if (r_max_fl > 4)     begin errors++; $display("FAIL bp_inflight: got %0d required <=4", r_max_fl); end
        checks++; if (r_hold_bad !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations required 0", r_hold_bad); end
        checks++; if (r_csum !== exp_sum(64)) begin errors++; $display("FAIL bp_checksum: got %0h required %0h", r_csum, exp_sum(64)); end
    endtask

    task automatic test_start_while_busy();
        for (int k = 0; k < 1024; k++) src_mem[k] = $urandom;
        run_xfer(0, 0, 0, 20, 400);
        checks++; if (r_end_cnt !== 1) begin errors++; $display("FAIL busy_start_end_count: got %0d required 1", r_end_cnt); end
        checks++; if (r_nacc !== 64)   begin errors++; $display("FAIL busy_start_writes: got %0d required 64", r_nacc); end
        checks++; if (r_bad !== 0)     begin errors++; $display("FAIL busy_start_order: got %0d bad writes required 0", r_bad); end
    endtask

    task automatic test_abort();
        frame_time = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        run_xfer(0, 0, 10, -1, 400);
        checks++; if (r_abort_cyc !== r_trig + 1) begin errors++; $display("FAIL abort_cycle: got %0d required %0d", r_abort_cyc, r_trig + 1); end
        checks++; if (r_abort_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", r_abort_busy); end
        checks++; if (r_end_cnt !== 0)       begin errors++; $display("FAIL abort_no_end: got %0d required 0", r_end_cnt); end
        checks++; if (frame_time !== 4'd4)   begin errors++; $display("FAIL abort_frame_step: got %0d required 4", frame_time); end
        for (int k = 0; k < 1024; k++) src_mem[k] = $urandom;
        run_xfer(0, 0, 0, -1, 400);
        checks++; if (r_nacc !== 64)    begin errors++; $display("FAIL restart_writes: got %0d required 64", r_nacc); end
        checks++; if (r_bad !== 0)      begin errors++; $display("FAIL restart_order: got %0d bad writes required 0", r_bad); end
        checks++; if (r_end_cyc !== 68) begin errors++; $display("FAIL restart_end_cycle: got %0d required 68", r_end_cyc); end
    endtask

    task automatic test_edge_sizes();
        for (int k = 0; k < 1024; k++) src_mem[k] = $urandom;
        run_xfer(1, 0, 0, -1, 50);
        checks++; if (r_first_we !== 3) begin errors++; $display("FAIL n1_first_we: got %0d required 3", r_first_we); end
        checks++; if (r_end_cyc !== 4)  begin errors++; $display("FAIL n1_end_cycle: got %0d required 4", r_end_cyc); end
        checks++; if (r_nacc !== 1 || r_bad !== 0) begin errors++; $display("FAIL n1_write: got %0d writes %0d bad required 1 0", r_nacc, r_bad); end
        run_xfer(2, 0, 0, -1, 5000);
        checks++; if (r_nacc !== 1023)      begin errors++; $display("FAIL n1023_writes: got %0d required 1023", r_nacc); end
        checks++; if (r_last_addr !== 1022) begin errors++; $display("FAIL n1023_last_addr: got %0d required 1022", r_last_addr); end
        checks++; if (r_bad !== 0)          begin errors++; $display("FAIL n1023_order: got %0d bad writes required 0", r_bad); end
        checks++; if (r_end_cnt !== 1)      begin errors++; $display("FAIL n1023_end_count: got %0d required 1", r_end_cnt); end
        checks++; if (r_csum !== exp_sum(1023)) begin errors++; $display("FAIL n1023_checksum: got %0h required %0h", r_csum, exp_sum(1023)); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset: got %b required 1", busy[0]); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({src_rd[0], src_addr[0], dst_we[0], dst_addr[0], dst_data[0], param_end[0], busy[0], abort_p[0], checksum[0]} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got busy=%b rd=%b we=%b addr=%0d data=%0h, required all zero",
                     busy[0], src_rd[0], dst_we[0], dst_addr[0], dst_data[0]);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (busy[0] !== 1'b0 || src_rd[0] !== 1'b0 || dst_we[0] !== 1'b0 || param_end[0] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got busy=%b rd=%b we=%b end=%b required 0 0 0 0",
                         busy[0], src_rd[0], dst_we[0], param_end[0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        frame_time = 4'h7;
        dst_ready = 1'b1;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        for (int k = 0; k < 1024; k++) src_mem[k] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        test_reset();
        test_nominal();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_edge_sizes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
